cache_fill_ctrl: RTL and testbench

//   Parametrised cache-miss fill controller: fetches one cache block, word by word, from a

---
 rtl/cache_fill_if.sv | 37 +++
 rtl/cache_fill_ctrl.sv | 97 +++++++++
 tb/tb_cache_fill_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_fill_if.sv
// Bus of the cache fill controller: miss request from tag logic, pipelined memory
// read port and cache array write side. master = fill controller, slave = its environment.
interface cache_fill_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int WORDS  = 8
);
   localparam int IDX_W = $clog2(WORDS);

   // Request handshake: a read transfers on a cycle with mem_req & mem_ready both high;
   // mem_req and mem_addr hold until then. Returns carry no ready and arrive in issue order.
   logic              miss_detected;
   logic [ADDR_W-1:0] miss_address;
   logic              mem_req;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_data_valid;
   logic [DATA_W-1:0] mem_data;
   logic              fsm_busy;
   logic              write_data_array;
   logic [IDX_W-1:0]  data_word_idx;
   logic [DATA_W-1:0] data_out;
   logic              write_tag_array;
   logic [ADDR_W-1:0] fill_addr;

   modport master (
      input  miss_detected, miss_address, mem_ready, mem_data_valid, mem_data,
      output mem_req, mem_addr, fsm_busy, write_data_array, data_word_idx, data_out,
             write_tag_array, fill_addr
   );

   modport slave (
      output miss_detected, miss_address, mem_ready, mem_data_valid, mem_data,
      input  mem_req, mem_addr, fsm_busy, write_data_array, data_word_idx, data_out,
             write_tag_array, fill_addr
   );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Cache-miss fill controller: fetches one block word by word from a pipelined memory,
// optionally critical-word-first, and drives the data/tag array write enables.
module cache_fill_ctrl #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16,
   parameter int WORDS    = 8,
   parameter int BYTE_OFF = 1,
   parameter int CWF      = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   cache_fill_if.master  bus,
   output logic          state_dbg
);
   localparam int IDX_W = $clog2(WORDS);
   localparam int CNT_W = IDX_W + 1;
   localparam int OFF_W = BYTE_OFF + IDX_W;
   localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((64'd1 << OFF_W) - 64'd1);
   localparam logic [CNT_W-1:0]  CNT_WORDS = CNT_W'(WORDS);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WORDS - 1);

   typedef enum logic {S_IDLE = 1'b0, S_FILL = 1'b1} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] fill_addr_q;
   logic [IDX_W-1:0]  start_q;
   logic [CNT_W-1:0]  iss_cnt, ret_cnt;
   logic [IDX_W-1:0]  iss_idx, ret_idx;
   logic              req, issue_fire, ret_fire;

   // Word indices wrap inside IDX_W bits so the block base is never disturbed.
   assign iss_idx = start_q + iss_cnt[IDX_W-1:0];
   assign ret_idx = start_q + ret_cnt[IDX_W-1:0];

   always_comb begin
      state_nxt            = state;
      req                  = 1'b0;
      ret_fire             = 1'b0;
      bus.mem_req          = 1'b0;
      bus.mem_addr         = '0;
      bus.fsm_busy         = 1'b0;
      bus.write_data_array = 1'b0;
      bus.data_word_idx    = '0;
      bus.data_out         = '0;
      bus.write_tag_array  = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.miss_detected) state_nxt = S_FILL;
         end
         S_FILL: begin
            bus.fsm_busy      = 1'b1;
            req               = (iss_cnt < CNT_WORDS);
            bus.mem_req       = req;
            bus.mem_addr      = fill_addr_q | (ADDR_W'(iss_idx) << BYTE_OFF);
            bus.data_word_idx = ret_idx;
            // Beats with nothing outstanding are stray and must not write the array.
            if (bus.mem_data_valid && (ret_cnt < iss_cnt)) begin
               ret_fire             = 1'b1;
               bus.write_data_array = 1'b1;
               bus.data_out         = bus.mem_data;
               if (ret_cnt == CNT_LAST) begin
                  bus.write_tag_array = 1'b1;
                  state_nxt           = S_IDLE;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      issue_fire = req & bus.mem_ready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         fill_addr_q <= '0;
         start_q     <= '0;
         iss_cnt     <= '0;
         ret_cnt     <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE) begin
            if (bus.miss_detected) begin
               fill_addr_q <= bus.miss_address & ~OFF_MASK;
               start_q     <= (CWF != 0) ? bus.miss_address[BYTE_OFF +: IDX_W] : '0;
               iss_cnt     <= '0;
               ret_cnt     <= '0;
            end
         end else begin
            if (issue_fire) iss_cnt <= iss_cnt + CNT_W'(1);
            if (ret_fire)   ret_cnt <= ret_cnt + CNT_W'(1);
         end
      end
   end

   assign bus.fill_addr = fill_addr_q;
   assign state_dbg     = (state == S_FILL);
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: three configurations (CWF=0, CWF=1, 32-bit/4-word) each
// with its own pipelined memory model and a transaction-level scoreboard.
module tb_cache_fill_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Stimulus controls, written at posedge+2 and read by the per-config models at negedge.
   logic        miss_on   = 1'b0;
   int          miss_sel  = 0;
   logic [31:0] miss_addr = '0;
   int          lat       = 1;
   int          rmode     = 0;
   logic        junk_on   = 1'b0;

   logic        m_busy_a     [3];
   int          busy_cnt_a   [3];
   int          wr_cnt_a     [3];
   logic [31:0] first_addr_a [3];
   logic [31:0] fill_seen_a  [3];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] mem_word(input logic [31:0] a);
      return a[15:0] ^ a[31:16] ^ 16'hC3A5 ^ {a[3:0], 12'h000};
   endfunction

   for (genvar g = 0; g < 3; g++) begin : gi
      localparam int AW = (g == 2) ? 32 : 16;
      localparam int WD = (g == 2) ? 4 : 8;
      localparam int BO = (g == 2) ? 2 : 1;
      localparam int CW = (g == 1) ? 1 : 0;
      localparam int IW = $clog2(WD);

      logic state_dbg;
      cache_fill_if #(.ADDR_W(AW), .DATA_W(16), .WORDS(WD)) bus ();
      cache_fill_ctrl #(.ADDR_W(AW), .DATA_W(16), .WORDS(WD), .BYTE_OFF(BO), .CWF(CW)) dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .bus       (bus.master),
         .state_dbg (state_dbg)
      );

      initial begin : model
         logic [AW-1:0] exp_addr_q[$];
         int            exp_idx_q[$];
         logic [AW-1:0] pend_addr_q[$];
         int            pend_due_q[$];
         logic          m_busy, nb, real_v, first_pend, r, exp_req, exp_wr;
         int            cyc, fcyc, st, ei;
         logic [AW-1:0] ma, base, a;
         m_busy = 1'b0; real_v = 1'b0; first_pend = 1'b0; cyc = 0; fcyc = 0; base = '0;
         m_busy_a[g] = 1'b0; busy_cnt_a[g] = 0; wr_cnt_a[g] = 0;
         first_addr_a[g] = '0; fill_seen_a[g] = '0;
         bus.miss_detected = 1'b0; bus.miss_address = '0; bus.mem_ready = 1'b0;
         bus.mem_data_valid = 1'b0; bus.mem_data = '0;
         forever begin
            @(negedge clk);
            cyc++;
            bus.miss_detected = miss_on && (miss_sel == g);
            bus.miss_address  = AW'(miss_addr);
            case (rmode)
               0:       r = 1'b1;
               1:       r = ((fcyc % 3) == 0);
               default: r = 1'($urandom_range(0, 1));
            endcase
            bus.mem_ready      = r;
            real_v             = 1'b0;
            bus.mem_data_valid = 1'b0;
            bus.mem_data       = 16'($urandom);
            if (pend_due_q.size() > 0 && pend_due_q[0] <= cyc) begin
               real_v             = 1'b1;
               bus.mem_data_valid = 1'b1;
               bus.mem_data       = mem_word(32'(pend_addr_q[0]));
            end else if (junk_on && pend_due_q.size() == 0) begin
               bus.mem_data_valid = 1'($urandom_range(0, 1));
            end
            #1;
            if (!rst_n) begin
               chk("rst_req",  bus.mem_req, 0);
               chk("rst_addr", bus.mem_addr, 0);
               chk("rst_busy", bus.fsm_busy, 0);
               chk("rst_wr",   bus.write_data_array, 0);
               chk("rst_idx",  bus.data_word_idx, 0);
               chk("rst_data", bus.data_out, 0);
               chk("rst_tag",  bus.write_tag_array, 0);
               chk("rst_fill", bus.fill_addr, 0);
               chk("rst_dbg",  state_dbg, 0);
               exp_addr_q.delete(); exp_idx_q.delete();
               pend_addr_q.delete(); pend_due_q.delete();
               m_busy = 1'b0; m_busy_a[g] = 1'b0; fcyc = 0;
            end else begin
               nb = m_busy;
               chk("busy", bus.fsm_busy, m_busy);
               chk("state_dbg", state_dbg, m_busy);
               if (m_busy) chk("fill_addr", bus.fill_addr, base);
               if (m_busy && fcyc == 0) fill_seen_a[g] = 32'(bus.fill_addr);
               if (bus.fsm_busy) busy_cnt_a[g]++;
               exp_req = m_busy && (exp_addr_q.size() > 0);
               chk("req", bus.mem_req, exp_req);
               if (exp_req) begin
                  chk("mem_addr", bus.mem_addr, exp_addr_q[0]);
                  if (bus.mem_ready) begin
                     a = exp_addr_q.pop_front();
                     pend_addr_q.push_back(a);
                     pend_due_q.push_back(cyc + lat);
                     if (first_pend) first_addr_a[g] = 32'(a);
                     first_pend = 1'b0;
                  end
               end
               exp_wr = m_busy && real_v;
               chk("write", bus.write_data_array, exp_wr);
               if (exp_wr) begin
                  a = pend_addr_q.pop_front();
                  void'(pend_due_q.pop_front());
                  ei = exp_idx_q.pop_front();
                  chk("word_idx", bus.data_word_idx, ei);
                  chk("data_out", bus.data_out, mem_word(32'(a)));
                  chk("tag_last", bus.write_tag_array, exp_idx_q.size() == 0);
                  wr_cnt_a[g]++;
                  if (exp_idx_q.size() == 0) nb = 1'b0;
               end else begin
                  chk("tag_quiet", bus.write_tag_array, 0);
               end
               if (!m_busy && bus.miss_detected) begin
                  ma   = bus.miss_address;
                  base = ma & ~AW'((64'd1 << (BO + IW)) - 64'd1);
                  st   = (CW != 0) ? int'((64'(ma) >> BO) % WD) : 0;
                  exp_addr_q.delete(); exp_idx_q.delete();
                  for (int i = 0; i < WD; i++) begin
                     exp_idx_q.push_back((st + i) % WD);
                     exp_addr_q.push_back(base + AW'(((st + i) % WD) << BO));
                  end
                  busy_cnt_a[g] = 0; wr_cnt_a[g] = 0; first_pend = 1'b1;
                  nb = 1'b1; fcyc = 0;
               end else begin
                  fcyc++;
               end
               m_busy = nb; m_busy_a[g] = nb;
            end
         end
      end
   end

   typedef struct {
      int          cfg;
      logic [31:0] miss;
      int          mode;
      int          lat;
      logic        junk;
      logic        mif;
      logic [31:0] exp_fill;
      logic [31:0] exp_first;
      int          exp_busy;
      int          exp_words;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_busy(input int k, input logic lvl, input int lim, input string name);
      int n;
      n = 0;
      while (m_busy_a[k] !== lvl && n < lim) begin
         tick();
         n++;
      end
      n_checks++;
      if (m_busy_a[k] !== lvl) begin
         n_fail++;
         $display("FAIL %s: busy still %0b after %0d cycles, wanted %0b", name, m_busy_a[k], lim, lvl);
      end
   endtask

   task automatic start_fill(input int k, input logic [31:0] a);
      miss_sel  = k;
      miss_addr = a;
      miss_on   = 1'b1;
      tick();
      miss_on   = 1'b0;
   endtask

   initial begin : main
      vec_t vt[6];
      int   n, k;
      vt[0] = '{0, 32'h0000_1234, 0, 4, 1'b0, 1'b0, 32'h0000_1230, 32'h0000_1230, 12, 8};
      vt[1] = '{1, 32'h0000_123A, 0, 4, 1'b0, 1'b0, 32'h0000_1230, 32'h0000_123A, 12, 8};
      vt[2] = '{0, 32'h0000_5678, 1, 2, 1'b0, 1'b0, 32'h0000_5670, 32'h0000_5670, 24, 8};
      vt[3] = '{1, 32'h0000_00FE, 0, 1, 1'b1, 1'b1, 32'h0000_00F0, 32'h0000_00FE,  9, 8};
      vt[4] = '{2, 32'h0000_0FFC, 0, 3, 1'b0, 1'b0, 32'h0000_0FF0, 32'h0000_0FF0,  7, 4};
      vt[5] = '{2, 32'hFFFF_FFFE, 1, 2, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 12, 4};

      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 6; i++) begin
         k = vt[i].cfg; lat = vt[i].lat; rmode = vt[i].mode; junk_on = vt[i].junk;
         tick();
         start_fill(k, vt[i].miss);
         wait_busy(k, 1'b1, 5, "tbl_start");
         if (vt[i].mif) begin
            for (int j = 0; j < 3; j++) begin
               miss_on = 1'b1;
               miss_addr = $urandom;
               tick();
            end
            miss_on = 1'b0;
         end
         wait_busy(k, 1'b0, 200, "tbl_done");
         chk("tbl_fill_addr", fill_seen_a[k], vt[i].exp_fill);
         chk("tbl_first_addr", first_addr_a[k], vt[i].exp_first);
         chk("tbl_busy_cycles", busy_cnt_a[k], vt[i].exp_busy);
         chk("tbl_writes", wr_cnt_a[k], vt[i].exp_words);
         repeat (2) tick();
      end
      junk_on = 1'b0;

      // Reset mid-fill after three returns, then a clean refill from the first word.
      lat = 4; rmode = 0;
      start_fill(0, 32'h0000_1234);
      n = 0;
      while (wr_cnt_a[0] < 3 && n < 40) begin
         tick();
         n++;
      end
      chk("rst_reach_3", wr_cnt_a[0] >= 3, 1);
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      start_fill(0, 32'h0000_1234);
      wait_busy(0, 1'b0, 200, "refill_done");
      chk("refill_first", first_addr_a[0], 32'h0000_1230);
      chk("refill_busy", busy_cnt_a[0], 12);
      chk("refill_writes", wr_cnt_a[0], 8);

      // Miss held across the exit cycle: exactly one idle cycle before the next fill.
      lat = 2; rmode = 0; miss_sel = 2; miss_addr = 32'h0000_0ABC; miss_on = 1'b1;
      wait_busy(2, 1'b1, 5, "b2b_start");
      wait_busy(2, 1'b0, 100, "b2b_first_done");
      n = 0;
      while (!gi[2].bus.fsm_busy && n < 10) begin
         tick();
         n++;
      end
      chk("b2b_gap", n, 1);
      miss_on = 1'b0;
      wait_busy(2, 1'b0, 100, "b2b_second_done");
      tick();

      for (int i = 0; i < 15; i++) begin
         k = $urandom_range(0, 2);
         lat = $urandom_range(1, 5);
         rmode = $urandom_range(0, 2);
         junk_on = 1'($urandom_range(0, 1));
         start_fill(k, $urandom);
         wait_busy(k, 1'b1, 5, "rnd_start");
         wait_busy(k, 1'b0, 400, "rnd_done");
         chk("rnd_writes", wr_cnt_a[k], (k == 2) ? 4 : 8);
         repeat ($urandom_range(0, 3)) tick();
      end
      junk_on = 1'b0;
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
